// File: rtl/cnn_pkg.sv
// cnn_pkg
// Shared types and constants for the CNN pipeline blocks.
//   fp16_t        : raw IEEE half-precision word
//   FP16_*        : field positions and special values of the FP16 format
//   pool_state_t  : column-pairing state of the pooling stage
//   fp16_relu()   : ReLU on a raw FP16 word (negatives and NaNs become +0)
package cnn_pkg;

  typedef logic [15:0] fp16_t;

  localparam fp16_t      FP16_ZERO     = 16'h0000;
  localparam int         FP16_SIGN_BIT = 15;
  localparam int         FP16_EXP_MSB  = 14;
  localparam int         FP16_EXP_LSB  = 10;
  localparam int         FP16_MANT_MSB = 9;
  localparam logic [4:0] FP16_EXP_MAX  = 5'h1F;

  typedef enum logic {
    WAIT_ODD,
    WAIT_EVEN
  } pool_state_t;

  // Any set sign bit (including -0 and negative NaN) maps to +0, and so does
  // any NaN. Infinity and all non-negative numbers pass untouched.
  function automatic fp16_t fp16_relu(input fp16_t x);
    if (x[FP16_SIGN_BIT])
      return FP16_ZERO;
    if ((x[FP16_EXP_MSB:FP16_EXP_LSB] == FP16_EXP_MAX) && (x[FP16_MANT_MSB:0] != '0))
      return FP16_ZERO;
    return x;
  endfunction

endpackage

// File: rtl/fp16_relu_max2.sv
// fp16_relu_max2
// Combinational ReLU-then-max of two FP16 words.
//   a, b : FP16 operands
//   y    : max(relu(a), relu(b))
module fp16_relu_max2
  import cnn_pkg::*;
(
  input  fp16_t a,
  input  fp16_t b,
  output fp16_t y
);

  fp16_t relu_a;
  fp16_t relu_b;

  assign relu_a = fp16_relu(a);
  assign relu_b = fp16_relu(b);

  // After ReLU both values are non-negative and non-NaN, so the FP16 ordering
  // matches the unsigned ordering of exponent and mantissa bits.
  assign y = (relu_a[14:0] >= relu_b[14:0]) ? relu_a : relu_b;

endmodule

// File: rtl/relu_maxpool_col.sv
// relu_maxpool_col
// ReLU followed by 2x2 stride-2 max pooling on a column-streamed conv map.
// One input column per in_valid. One pooled column is produced per completed
// odd/even column pair.
//   clk, rst           : clock, asynchronous active-low reset
//   frame_start        : restart pairing and clear sticky errors
//   in_valid/in_col_num/in_data    : input column (index 1..IN_COLS)
//   out_valid/out_ready            : output handshake
//   out_data/out_col_num           : pooled column (index 0..OUT_COLS-1)
//   frame_done         : pulse after the last pooled column is accepted
//   err_seq, err_ovf   : sticky sequence / overflow errors
module relu_maxpool_col
  import cnn_pkg::*;
#(
  parameter  int DATA_WIDTH  = 16,
  parameter  int IMAGE_SIZE  = 28,
  parameter  int KERNEL_SIZE = 5,
  parameter  int IN_COLS     = IMAGE_SIZE - KERNEL_SIZE + 1,
  localparam int OUT_COLS    = IN_COLS / 2,
  localparam int COL_W       = $clog2(IMAGE_SIZE) + 1,
  localparam int OUT_COL_W   = $clog2(OUT_COLS) + 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 frame_start,
  input  logic                                 in_valid,
  input  logic [COL_W-1:0]                     in_col_num,
  input  logic [IN_COLS-1:0][DATA_WIDTH-1:0]   in_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [OUT_COLS-1:0][DATA_WIDTH-1:0]  out_data,
  output logic [OUT_COL_W-1:0]                 out_col_num,
  output logic                                 frame_done,
  output logic                                 err_seq,
  output logic                                 err_ovf
);

  localparam logic [COL_W-1:0]     IN_COLS_C = COL_W'(IN_COLS);
  localparam logic [OUT_COL_W-1:0] LAST_COL  = OUT_COL_W'(OUT_COLS - 1);

  pool_state_t state;
  pool_state_t state_eff;
  pool_state_t state_next;

  logic [OUT_COLS-1:0][DATA_WIDTH-1:0] vert;
  logic [OUT_COLS-1:0][DATA_WIDTH-1:0] held;
  logic [OUT_COLS-1:0][DATA_WIDTH-1:0] pooled;
  logic [COL_W-1:0]                    expected;
  logic [OUT_COL_W-1:0]                pool_idx;

  logic col_in_range;
  logic load_held;
  logic complete;
  logic seq_set;
  logic ovf_set;
  logic handshake;

  // Vertical pair max of the incoming column, then horizontal max against the
  // held odd column. The second ReLU is a no-op on already rectified values.
  for (genvar j = 0; j < OUT_COLS; j++) begin : g_pool
    fp16_relu_max2 u_vert (
      .a (in_data[2*j]),
      .b (in_data[2*j+1]),
      .y (vert[j])
    );
    fp16_relu_max2 u_horz (
      .a (held[j]),
      .b (vert[j]),
      .y (pooled[j])
    );
  end

  assign col_in_range = (in_col_num != '0) && (in_col_num <= IN_COLS_C);
  assign pool_idx     = OUT_COL_W'((in_col_num >> 1) - COL_W'(1));
  assign handshake    = out_valid && out_ready;
  assign ovf_set      = complete && out_valid && !out_ready;

  // Pairing state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= WAIT_ODD;
    else
      state <= state_next;
  end

  // Next-state decode. frame_start restarts pairing in the same cycle, so a
  // coincident column is judged as if the FSM were already in WAIT_ODD.
  // An odd column arriving in WAIT_EVEN restarts the pair from that column.
  always_comb begin
    state_eff  = frame_start ? WAIT_ODD : state;
    state_next = state_eff;
    load_held  = 1'b0;
    complete   = 1'b0;
    seq_set    = 1'b0;
    if (in_valid) begin
      if (!col_in_range) begin
        seq_set    = 1'b1;
        state_next = WAIT_ODD;
      end else begin
        case (state_eff)
          WAIT_ODD: begin
            if (in_col_num[0]) begin
              load_held  = 1'b1;
              state_next = WAIT_EVEN;
            end else begin
              seq_set = 1'b1;
            end
          end
          WAIT_EVEN: begin
            if (in_col_num == expected) begin
              complete   = 1'b1;
              state_next = WAIT_ODD;
            end else if (in_col_num[0]) begin
              seq_set    = 1'b1;
              load_held  = 1'b1;
              state_next = WAIT_EVEN;
            end else begin
              seq_set    = 1'b1;
              state_next = WAIT_ODD;
            end
          end
          default: state_next = WAIT_ODD;
        endcase
      end
    end
  end

  // Odd column store and the even column index that must follow it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      held     <= '0;
      expected <= '0;
    end else if (load_held) begin
      held     <= vert;
      expected <= in_col_num + COL_W'(1);
    end
  end

  // Sticky errors. frame_start clears them, but an error raised by a column
  // arriving in that same cycle still sticks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_seq <= 1'b0;
      err_ovf <= 1'b0;
    end else begin
      err_seq <= (err_seq && !frame_start) || seq_set;
      err_ovf <= (err_ovf && !frame_start) || ovf_set;
    end
  end

  // Output register. A new result takes the slot when it is empty or being
  // accepted this cycle. Otherwise the new result is dropped and the pending
  // one is kept stable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_col_num <= '0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= handshake && (out_col_num == LAST_COL);
      if (complete && (!out_valid || out_ready)) begin
        out_valid   <= 1'b1;
        out_data    <= pooled;
        out_col_num <= pool_idx;
      end else if (handshake) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_relu_maxpool_col.sv
// tb_relu_maxpool_col
// Directed bench for relu_maxpool_col with hand-computed expected values.
module tb_relu_maxpool_col;

  typedef logic [23:0][15:0] col_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               frame_start;
  logic               in_valid;
  logic [5:0]         in_col_num;
  col_t               in_data;
  logic               out_valid;
  logic               out_ready;
  logic [11:0][15:0]  out_data;
  logic [4:0]         out_col_num;
  logic               frame_done;
  logic               err_seq;
  logic               err_ovf;

  int tests_run    = 0;
  int tests_failed = 0;
  int fd_count     = 0;
  int fd_before;

  relu_maxpool_col dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .in_valid    (in_valid),
    .in_col_num  (in_col_num),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_col_num (out_col_num),
    .frame_done  (frame_done),
    .err_seq     (err_seq),
    .err_ovf     (err_ovf)
  );

  always #5 clk = ~clk;

  // Counts frame_done pulses, sampled away from the rising edge.
  always @(negedge clk) begin
    if (frame_done)
      fd_count <= fd_count + 1;
  end

  function automatic col_t col_fill(input logic [15:0] v);
    col_t c;
    for (int i = 0; i < 24; i++)
      c[i] = v;
    return c;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Presents one column for one cycle followed by one idle cycle. Returns on
  // a falling edge, one cycle after the column was sampled.
  task automatic applyStimulus(input logic [5:0] num, input col_t data, input logic fs);
    @(negedge clk);
    in_valid    = 1'b1;
    in_col_num  = num;
    in_data     = data;
    frame_start = fs;
    @(negedge clk);
    in_valid    = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic pulseFrameStart();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  col_t c;

  initial begin
    rst         = 1'b0;
    frame_start = 1'b0;
    in_valid    = 1'b0;
    in_col_num  = '0;
    in_data     = '0;
    out_ready   = 1'b1;
    repeat (3) @(negedge clk);

    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data0", 32'(out_data[0]), 32'h0);
    checkOutput("rst_col_num", 32'(out_col_num), 32'd0);
    checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
    checkOutput("rst_err_seq", 32'(err_seq), 32'd0);
    checkOutput("rst_err_ovf", 32'(err_ovf), 32'd0);
    rst = 1'b1;

    // Basic pair: row 0 of col 1 is 2.0, everything else 1.0 or 0.5.
    c = col_fill(16'h3C00);
    c[0] = 16'h4000;
    applyStimulus(6'd1, c, 1'b0);
    checkOutput("basic_no_early", 32'(out_valid), 32'd0);
    applyStimulus(6'd2, col_fill(16'h3800), 1'b0);
    checkOutput("basic_valid", 32'(out_valid), 32'd1);
    checkOutput("basic_idx", 32'(out_col_num), 32'd0);
    checkOutput("basic_d0", 32'(out_data[0]), 32'h4000);
    checkOutput("basic_d1", 32'(out_data[1]), 32'h3C00);
    checkOutput("basic_d11", 32'(out_data[11]), 32'h3C00);
    @(negedge clk);
    checkOutput("basic_drain", 32'(out_valid), 32'd0);

    // Negatives and NaNs rectify to zero.
    applyStimulus(6'd1, col_fill(16'hBC00), 1'b0);
    c = col_fill(16'hC000);
    c[0] = 16'h7E01;
    c[1] = 16'h7E01;
    applyStimulus(6'd2, c, 1'b0);
    checkOutput("neg_valid", 32'(out_valid), 32'd1);
    checkOutput("neg_d0", 32'(out_data[0]), 32'h0);
    checkOutput("neg_d1", 32'(out_data[1]), 32'h0);
    checkOutput("neg_d11", 32'(out_data[11]), 32'h0);

    // frame_start coincident with a column: that column restarts the pair
    // without raising a sequence error.
    applyStimulus(6'd1, col_fill(16'h4000), 1'b0);
    applyStimulus(6'd1, col_fill(16'h3C00), 1'b1);
    checkOutput("fs_coinc_err", 32'(err_seq), 32'd0);
    applyStimulus(6'd2, col_fill(16'h3800), 1'b0);
    checkOutput("fs_coinc_valid", 32'(out_valid), 32'd1);
    checkOutput("fs_coinc_d0", 32'(out_data[0]), 32'h3C00);

    // Full frame, one column every two cycles; pair k peaks at 0x3C00+2k+2.
    pulseFrameStart();
    fd_before = fd_count;
    for (int col = 1; col <= 24; col++) begin
      applyStimulus(6'(col), col_fill(16'(32'h3C00 + col)), 1'b0);
      if ((col % 2) == 0) begin
        checkOutput("frame_valid", 32'(out_valid), 32'd1);
        checkOutput("frame_idx", 32'(out_col_num), 32'(col / 2 - 1));
        checkOutput("frame_data", 32'(out_data[5]), 32'h3C00 + 32'(col));
      end
    end
    repeat (3) @(negedge clk);
    checkOutput("frame_done_once", 32'(fd_count - fd_before), 32'd1);
    checkOutput("frame_err_seq", 32'(err_seq), 32'd0);
    checkOutput("frame_err_ovf", 32'(err_ovf), 32'd0);
    checkOutput("frame_drained", 32'(out_valid), 32'd0);

    // Backpressure: second result is dropped, first one held.
    out_ready = 1'b0;
    applyStimulus(6'd1, col_fill(16'h4400), 1'b0);
    applyStimulus(6'd2, col_fill(16'h3C00), 1'b0);
    checkOutput("bp_first_valid", 32'(out_valid), 32'd1);
    checkOutput("bp_first_ovf", 32'(err_ovf), 32'd0);
    applyStimulus(6'd3, col_fill(16'h4800), 1'b0);
    applyStimulus(6'd4, col_fill(16'h4800), 1'b0);
    checkOutput("bp_held_valid", 32'(out_valid), 32'd1);
    checkOutput("bp_held_d0", 32'(out_data[0]), 32'h4400);
    checkOutput("bp_held_idx", 32'(out_col_num), 32'd0);
    checkOutput("bp_ovf", 32'(err_ovf), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release", 32'(out_valid), 32'd0);
    @(negedge clk);
    checkOutput("bp_no_second", 32'(out_valid), 32'd0);

    // Odd column while waiting for the even one replaces the held column.
    pulseFrameStart();
    checkOutput("fs_clear_ovf", 32'(err_ovf), 32'd0);
    applyStimulus(6'd1, col_fill(16'h5000), 1'b0);
    applyStimulus(6'd3, col_fill(16'h3C00), 1'b0);
    checkOutput("repl_err_seq", 32'(err_seq), 32'd1);
    applyStimulus(6'd4, col_fill(16'h3800), 1'b0);
    checkOutput("repl_valid", 32'(out_valid), 32'd1);
    checkOutput("repl_idx", 32'(out_col_num), 32'd1);
    checkOutput("repl_d0", 32'(out_data[0]), 32'h3C00);

    // Sequence errors: even column first, then out-of-range indices.
    pulseFrameStart();
    checkOutput("fs_clear_seq", 32'(err_seq), 32'd0);
    applyStimulus(6'd2, col_fill(16'h3C00), 1'b0);
    checkOutput("seq_even_err", 32'(err_seq), 32'd1);
    checkOutput("seq_even_noout", 32'(out_valid), 32'd0);
    pulseFrameStart();
    checkOutput("seq_cleared", 32'(err_seq), 32'd0);
    applyStimulus(6'd25, col_fill(16'h3C00), 1'b0);
    checkOutput("seq_col25_err", 32'(err_seq), 32'd1);
    pulseFrameStart();
    applyStimulus(6'd0, col_fill(16'h3C00), 1'b0);
    checkOutput("seq_col0_err", 32'(err_seq), 32'd1);
    pulseFrameStart();
    applyStimulus(6'd1, col_fill(16'h3C00), 1'b0);
    applyStimulus(6'd2, col_fill(16'h4000), 1'b0);
    checkOutput("seq_recover_valid", 32'(out_valid), 32'd1);
    checkOutput("seq_recover_idx", 32'(out_col_num), 32'd0);
    checkOutput("seq_recover_d0", 32'(out_data[0]), 32'h4000);
    checkOutput("seq_recover_err", 32'(err_seq), 32'd0);

    // Reset with a result pending and a column half-paired.
    out_ready = 1'b0;
    applyStimulus(6'd1, col_fill(16'h3C00), 1'b0);
    applyStimulus(6'd2, col_fill(16'h3C00), 1'b0);
    applyStimulus(6'd3, col_fill(16'h3C00), 1'b0);
    checkOutput("midrst_pending", 32'(out_valid), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_out_data", 32'(out_data[0]), 32'h0);
    rst = 1'b1;
    out_ready = 1'b1;
    applyStimulus(6'd4, col_fill(16'h3C00), 1'b0);
    checkOutput("midrst_err_seq", 32'(err_seq), 32'd1);
    checkOutput("midrst_no_out", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
